// File: rtl/hazard_sequencer_if.sv
// Pipeline-side bundle for the hazard sequencer: decode/execute hazard
// inputs and the stall/flush controls the sequencer returns.
interface hazard_sequencer_if;
    logic       id_valid_i;
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_uses_rs1_i;
    logic       id_uses_rs2_i;
    logic       dx_valid_i;
    logic [4:0] dx_rd_i;
    logic       dx_memread_i;
    logic       dx_ready_i;
    logic       branch_taken_i;
    logic       dx_valid_o;
    logic       fd_ready_o;
    logic       pc_hold_o;
    logic       dx_flush_o;

    // Pipeline side: presents hazard information, consumes controls.
    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        output dx_valid_i, dx_rd_i, dx_memread_i, dx_ready_i, branch_taken_i,
        input  dx_valid_o, fd_ready_o, pc_hold_o, dx_flush_o
    );

    // Sequencer side.
    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
        input  dx_valid_i, dx_rd_i, dx_memread_i, dx_ready_i, branch_taken_i,
        output dx_valid_o, fd_ready_o, pc_hold_o, dx_flush_o
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard sequencer: inserts a one-cycle bubble on load-use hazards and
// holds the pipeline flush for FlushCycles cycles after a taken branch.
// Stall/flush controls are combinational from state and current inputs;
// state and performance counters are registered.
module hazard_sequencer #(
    parameter int FlushCycles = 2,
    parameter int CountWidth  = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    hazard_sequencer_if.slave     hz,
    output logic [1:0]            state_o,
    output logic [CountWidth-1:0] stall_cnt_o,
    output logic [CountWidth-1:0] flush_cnt_o
);
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2
    } state_t;

    // Flush cycles still owed after the cycle the branch was taken.
    localparam logic [2:0] FlushExtra = 3'(FlushCycles - 1);

    state_t                state_reg;
    logic [2:0]            remaining_reg;
    logic [CountWidth-1:0] stall_cnt_reg;
    logic [CountWidth-1:0] flush_cnt_reg;

    logic load_use;
    logic branch_eff;
    logic flushing;
    logic stall_req;
    logic enter_stall;

    // Producer in DX is a load whose destination decode is about to read;
    // x0 is never a real dependency.
    assign load_use = hz.dx_valid_i & hz.dx_memread_i & (hz.dx_rd_i != 5'd0) & hz.id_valid_i &
                      ((hz.id_uses_rs1_i & (hz.id_rs1_i == hz.dx_rd_i)) |
                       (hz.id_uses_rs2_i & (hz.id_rs2_i == hz.dx_rd_i)));

    // A branch seen while reset is held must not raise the flush line.
    assign branch_eff  = hz.branch_taken_i & ~reset_i;
    assign flushing    = (state_reg == ST_FLUSH) | branch_eff;
    // The load has already advanced once we are in LOAD_STALL, so the
    // same comparison must not stall a second time.
    assign stall_req   = load_use & (state_reg != ST_LOAD_STALL);
    assign enter_stall = (state_reg == ST_RUN) & ~branch_eff & load_use & hz.dx_ready_i;

    // Pipeline controls: flush beats stall beats normal flow.
    always_comb begin
        hz.dx_valid_o = hz.id_valid_i;
        hz.fd_ready_o = hz.dx_ready_i;
        hz.pc_hold_o  = ~hz.dx_ready_i;
        hz.dx_flush_o = 1'b0;
        if (flushing) begin
            hz.dx_valid_o = 1'b0;
            hz.fd_ready_o = 1'b1;
            hz.pc_hold_o  = 1'b0;
            hz.dx_flush_o = 1'b1;
        end else if (stall_req) begin
            hz.dx_valid_o = 1'b0;
            hz.fd_ready_o = 1'b0;
            hz.pc_hold_o  = 1'b1;
        end
    end

    // State sequencing plus saturating stall/flush counters.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg     <= ST_RUN;
            remaining_reg <= 3'd0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_FLUSH: begin
                    if (remaining_reg <= 3'd1) begin
                        state_reg     <= ST_RUN;
                        remaining_reg <= 3'd0;
                    end else begin
                        remaining_reg <= remaining_reg - 3'd1;
                    end
                end
                default: begin
                    if (branch_eff) begin
                        if (FlushCycles > 1) begin
                            state_reg     <= ST_FLUSH;
                            remaining_reg <= FlushExtra;
                        end else begin
                            state_reg     <= ST_RUN;
                            remaining_reg <= 3'd0;
                        end
                    end else if (enter_stall) begin
                        state_reg <= ST_LOAD_STALL;
                    end else begin
                        state_reg <= ST_RUN;
                    end
                end
            endcase

            if (enter_stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CountWidth'(1);
            end
            if (hz.dx_flush_o && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + CountWidth'(1);
            end
        end
    end

    assign state_o     = state_reg;
    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed hazard scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_hazard_sequencer;
    localparam int FC  = 2;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    hazard_sequencer_if hz();
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    hazard_sequencer #(.FlushCycles(FC), .CountWidth(CW)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .hz          (hz.slave),
        .state_o     (state_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: pending flush cycles, whether the bubble was just
    // taken, and the two event tallies.
    int m_flush_left = 0;
    bit m_in_stall   = 0;
    int m_stall_cnt  = 0;
    int m_flush_cnt  = 0;
    bit e_valid, e_fdr, e_hold, e_flush, e_enter;
    int e_state;

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_load_use();
        return hz.dx_valid_i && hz.dx_memread_i && (hz.dx_rd_i != 0) && hz.id_valid_i &&
               ((hz.id_uses_rs1_i && (hz.id_rs1_i == hz.dx_rd_i)) ||
                (hz.id_uses_rs2_i && (hz.id_rs2_i == hz.dx_rd_i)));
    endfunction

    // Expected controls for the current cycle.
    task automatic m_outputs();
        bit br, lu;
        if (reset_i) begin
            m_flush_left = 0;
            m_in_stall   = 0;
            m_stall_cnt  = 0;
            m_flush_cnt  = 0;
        end
        br = hz.branch_taken_i && !reset_i;
        lu = m_load_use() && !m_in_stall;
        e_enter = 0;
        e_state = (m_flush_left > 0) ? 2 : (m_in_stall ? 1 : 0);
        if (m_flush_left > 0 || br) begin
            e_flush = 1; e_valid = 0; e_fdr = 1; e_hold = 0;
        end else if (lu) begin
            e_flush = 0; e_valid = 0; e_fdr = 0; e_hold = 1;
            e_enter = hz.dx_ready_i;
        end else begin
            e_flush = 0; e_valid = hz.id_valid_i; e_fdr = hz.dx_ready_i; e_hold = !hz.dx_ready_i;
        end
    endtask

    task automatic check_cycle(string tag);
        m_outputs();
        check_val({tag, ".state"}, 32'(state_o), 32'(e_state));
        check_val({tag, ".valid"}, 32'(hz.dx_valid_o), 32'(e_valid));
        check_val({tag, ".fdr"}, 32'(hz.fd_ready_o), 32'(e_fdr));
        check_val({tag, ".hold"}, 32'(hz.pc_hold_o), 32'(e_hold));
        check_val({tag, ".flush"}, 32'(hz.dx_flush_o), 32'(e_flush));
        check_val({tag, ".scnt"}, 32'(stall_cnt_o), 32'(m_stall_cnt));
        check_val({tag, ".fcnt"}, 32'(flush_cnt_o), 32'(m_flush_cnt));
        $display("cyc %-10s rst=%0b br=%0b lu=%0b rdy=%0b st=%0d v=%0b fdr=%0b hold=%0b fl=%0b sc=%0d fc=%0d",
                 tag, reset_i, hz.branch_taken_i, m_load_use(), hz.dx_ready_i, state_o,
                 hz.dx_valid_o, hz.fd_ready_o, hz.pc_hold_o, hz.dx_flush_o, stall_cnt_o, flush_cnt_o);
    endtask

    // Advance the model across the rising edge using this cycle's inputs.
    task automatic tick();
        @(posedge clk_i);
        m_outputs();
        if (!reset_i) begin
            if (e_flush) m_flush_cnt = (m_flush_cnt < SAT) ? m_flush_cnt + 1 : SAT;
            if (m_flush_left > 0) begin
                m_flush_left--;
                m_in_stall = 0;
            end else if (e_flush) begin
                m_flush_left = FC - 1;
                m_in_stall   = 0;
            end else if (e_enter) begin
                m_in_stall  = 1;
                m_stall_cnt = (m_stall_cnt < SAT) ? m_stall_cnt + 1 : SAT;
            end else begin
                m_in_stall = 0;
            end
        end
        #1;
    endtask

    // Called at posedge+1 with inputs already applied.
    task automatic cycle(string tag);
        #4;
        check_cycle(tag);
        tick();
    endtask

    task automatic set_idle();
        hz.id_valid_i     = 1'b1;
        hz.id_rs1_i       = 5'd1;
        hz.id_rs2_i       = 5'd2;
        hz.id_uses_rs1_i  = 1'b1;
        hz.id_uses_rs2_i  = 1'b1;
        hz.dx_valid_i     = 1'b0;
        hz.dx_rd_i        = 5'd0;
        hz.dx_memread_i   = 1'b0;
        hz.dx_ready_i     = 1'b1;
        hz.branch_taken_i = 1'b0;
    endtask

    // lw x5 in DX, decode reads x5 on rs2.
    task automatic set_load_use();
        set_idle();
        hz.dx_valid_i    = 1'b1;
        hz.dx_memread_i  = 1'b1;
        hz.dx_rd_i       = 5'd5;
        hz.id_rs1_i      = 5'd7;
        hz.id_rs2_i      = 5'd5;
    endtask

    task automatic do_reset();
        set_idle();
        reset_i = 1'b1;
        cycle("reset");
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        set_idle();
        @(posedge clk_i);
        #1;
        do_reset();

        // Load-use bubble, then LOAD_STALL passes the instruction through.
        set_load_use();
        cycle("lu_bubble");
        cycle("lu_stall");
        check_val("req031_scnt", 32'(stall_cnt_o), 32'd1);
        set_idle();
        cycle("lu_after");

        // x0 destination and unused rs2 never stall.
        do_reset();
        set_load_use();
        hz.dx_rd_i  = 5'd0;
        hz.id_rs2_i = 5'd0;
        cycle("rd_x0");
        set_load_use();
        hz.id_uses_rs2_i = 1'b0;
        cycle("no_rs2");
        check_val("req032_scnt", 32'(stall_cnt_o), 32'd0);

        // Branch: two flush cycles, repeat branch in FLUSH ignored.
        do_reset();
        hz.branch_taken_i = 1'b1;
        cycle("br_take");
        cycle("br_again");
        hz.branch_taken_i = 1'b0;
        cycle("br_done");
        check_val("req033_fcnt", 32'(flush_cnt_o), 32'd2);

        // Branch and load-use together: branch wins.
        do_reset();
        set_load_use();
        hz.branch_taken_i = 1'b1;
        cycle("br_lu");
        hz.branch_taken_i = 1'b0;
        cycle("br_lu_fl");
        cycle("br_lu_run");
        check_val("req034_scnt", 32'(stall_cnt_o), 32'd1);

        // Load-use under back-pressure: hold four cycles, stall once.
        do_reset();
        set_load_use();
        hz.dx_ready_i = 1'b0;
        repeat (3) cycle("lu_bp");
        hz.dx_ready_i = 1'b1;
        cycle("lu_bp_go");
        cycle("lu_bp_stl");
        check_val("req035_scnt", 32'(stall_cnt_o), 32'd1);

        // Asynchronous reset in the middle of a flush.
        do_reset();
        hz.branch_taken_i = 1'b1;
        cycle("br_pre_rst");
        hz.branch_taken_i = 1'b0;
        #1;
        reset_i = 1'b1;
        #1;
        check_val("arst_state", 32'(state_o), 32'd0);
        check_val("arst_flush", 32'(hz.dx_flush_o), 32'd0);
        check_val("arst_fcnt", 32'(flush_cnt_o), 32'd0);
        check_val("arst_scnt", 32'(stall_cnt_o), 32'd0);
        cycle("arst_hold");
        reset_i = 1'b0;
        cycle("arst_rel");

        // Randomized traffic with a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            hz.id_valid_i     = ($urandom_range(0, 7) != 0);
            hz.id_rs1_i       = 5'($urandom_range(0, 3));
            hz.id_rs2_i       = 5'($urandom_range(0, 3));
            hz.id_uses_rs1_i  = 1'($urandom_range(0, 1));
            hz.id_uses_rs2_i  = 1'($urandom_range(0, 1));
            hz.dx_valid_i     = ($urandom_range(0, 3) != 0);
            hz.dx_rd_i        = 5'($urandom_range(0, 3));
            hz.dx_memread_i   = 1'($urandom_range(0, 1));
            hz.dx_ready_i     = ($urandom_range(0, 3) != 0);
            hz.branch_taken_i = ($urandom_range(0, 7) == 0);
            reset_i           = ($urandom_range(0, 59) == 0);
            cycle("rand");
        end
        reset_i = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
